// File: rtl/ir_cmd_ctrl_if.sv
// Frame input from the IR decoder and the command stream handed to application logic.
interface ir_cmd_ctrl_if;
    logic [31:0] code_in;
    logic        new_code_in;
    logic [2:0]  error_in;
    logic [7:0]  cmd_out;
    logic        repeat_out;
    logic        cmd_valid_out;
    logic        cmd_ready_in;

    modport master (
        output code_in, new_code_in, error_in, cmd_ready_in,
        input  cmd_out, repeat_out, cmd_valid_out
    );

    modport slave (
        input  code_in, new_code_in, error_in, cmd_ready_in,
        output cmd_out, repeat_out, cmd_valid_out
    );
endinterface

// File: rtl/ir_cmd_ctrl.sv
// NEC command controller: validates decoded frames, filters by address, classifies
// press / auto-repeat, tracks key hold and queues commands in a show-ahead FIFO.
module ir_cmd_ctrl #(
    parameter logic [7:0] DEV_ADDR       = 8'h00,
    parameter bit         ADDR_FILTER    = 1'b1,
    parameter int         RELEASE_CYCLES = 12_000_000,
    parameter int         REPEAT_SKIP    = 3,
    parameter int         FIFO_DEPTH     = 4
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    ir_cmd_ctrl_if.slave bus,
    output logic         key_held_out,
    output logic [7:0]   err_count_out,
    output logic [2:0]   last_err_out
);

    localparam int GAP_W = $clog2(RELEASE_CYCLES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(RELEASE_CYCLES);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       SKIP_C  = 8'(REPEAT_SKIP);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t            state_q, state_d;
    logic              latch_frame;
    logic              overrun;
    logic [31:0]       frame_q;

    logic [GAP_W-1:0]  gap_q;
    logic              key_held_q;
    logic [7:0]        last_cmd_q;
    logic [7:0]        hold_cnt_q;
    logic [7:0]        err_count_q;
    logic [2:0]        last_err_q;

    logic [8:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [8:0]        shown_q;

    logic [7:0]        f_addr, f_naddr, f_cmd, f_ncmd;
    logic              in_check, fmt_ok, addr_ok, accept, is_press;
    logic [7:0]        hold_next;
    logic              want_push, fifo_valid, fifo_full, pop, push, push_drop;
    logic              err_hit;
    logic [2:0]        err_code;
    logic [8:0]        head;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_frame) frame_q <= bus.code_in;
        end
    end

    // A strobe that lands while the previous frame is being evaluated cannot be held anywhere.
    always_comb begin
        state_d     = state_q;
        latch_frame = 1'b0;
        overrun     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.new_code_in) begin
                    latch_frame = 1'b1;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                overrun = bus.new_code_in;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        {f_addr, f_naddr, f_cmd, f_ncmd} = frame_q;
        in_check   = (state_q == CHECK);
        fmt_ok     = (f_addr == ~f_naddr) && (f_cmd == ~f_ncmd);
        addr_ok    = !ADDR_FILTER || (f_addr == DEV_ADDR);
        accept     = in_check && fmt_ok && addr_ok;
        is_press   = !key_held_q || (f_cmd != last_cmd_q);
        hold_next  = is_press ? 8'd0 : ((hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1);
        want_push  = accept && (is_press || (hold_next >= SKIP_C));
        fifo_valid = (count_q != '0);
        fifo_full  = (count_q == DEPTH_C);
        pop        = fifo_valid && bus.cmd_ready_in;
        push       = want_push && (!fifo_full || pop);
        push_drop  = want_push && fifo_full && !pop;
        head       = mem[rd_ptr_q];
    end

    // Only one error is counted per cycle; the highest-priority source names it.
    always_comb begin
        err_hit  = 1'b1;
        err_code = 3'b000;
        if (bus.error_in != 3'b000)      err_code = bus.error_in;
        else if (overrun)                err_code = 3'b111;
        else if (push_drop)              err_code = 3'b100;
        else if (in_check && !fmt_ok)    err_code = 3'b101;
        else if (in_check && !addr_ok)   err_code = 3'b110;
        else                             err_hit  = 1'b0;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_count_q <= '0;
            last_err_q  <= '0;
        end else if (err_hit) begin
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            last_err_q <= err_code;
        end
    end

    // Hold state follows every accepted frame, even one the full FIFO had to drop.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            gap_q      <= '0;
            key_held_q <= 1'b0;
            last_cmd_q <= '0;
            hold_cnt_q <= '0;
        end else if (accept) begin
            gap_q      <= '0;
            key_held_q <= 1'b1;
            last_cmd_q <= f_cmd;
            hold_cnt_q <= hold_next;
        end else if (gap_q != GAP_MAX) begin
            gap_q <= gap_q + GAP_W'(1);
            if (gap_q + GAP_W'(1) == GAP_MAX) key_held_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            shown_q  <= '0;
        end else begin
            if (fifo_valid) shown_q <= head;
            if (push) begin
                mem[wr_ptr_q] <= {f_cmd, !is_press};
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // When empty the outputs keep showing the last head rather than a stale slot.
    assign bus.cmd_out       = fifo_valid ? head[8:1] : shown_q[8:1];
    assign bus.repeat_out    = fifo_valid ? head[0]   : shown_q[0];
    assign bus.cmd_valid_out = fifo_valid;
    assign key_held_out      = key_held_q;
    assign err_count_out     = err_count_q;
    assign last_err_out      = last_err_q;

endmodule
